// File: rtl/burst_grant_responder.sv
// burst_grant_responder
// On a held request, emit GRANT_COUNT single-cycle grant pulses spaced GAP
// idle cycles apart. One cycle after the last grant, check that the requester
// has let go of req. Report the outcome as a one-cycle done, proto_err or
// abort pulse. err_cnt is a saturating tally of the error pulses.
module burst_grant_responder #(
    parameter int GRANT_COUNT = 3,
    parameter int GAP         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       grant,
    output logic       busy,
    output logic       done,
    output logic       proto_err,
    output logic       abort,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        GAP_WAIT,
        GRANT,
        CHECK,
        REPORT
    } state_t;

    localparam logic [3:0] GAP_L = 4'(GAP);
    localparam logic [3:0] GC_L  = 4'(GRANT_COUNT);

    state_t     r_state;
    logic [3:0] r_gap;
    logic [3:0] r_gcnt;
    logic       r_grant;
    logic       r_busy;
    logic       r_done;
    logic       r_perr;
    logic       r_abort;
    logic [7:0] r_err_cnt;

    state_t     w_state_nxt;
    logic [3:0] w_gap_nxt;
    logic [3:0] w_gcnt_nxt;
    logic       w_grant_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_perr_nxt;
    logic       w_abort_nxt;
    logic [3:0] w_gap_dec;
    logic [3:0] w_gcnt_inc;

    assign w_gap_dec  = r_gap - 4'd1;
    assign w_gcnt_inc = r_gcnt + 4'd1;

    // The state and every output are registered. Each output flop therefore
    // shows, during a cycle, what the FSM decided on the preceding edge.
    //
    // REPORT is the cycle in which the outcome pulse is visible. It accepts a
    // new request exactly like IDLE, so that a requester that never dropped req
    // restarts on the very edge that sees the proto_err pulse.
    //
    // The gap counter is decremented and tested in the same cycle. The FSM
    // therefore steps into GRANT on the edge where the counter reaches zero.
    // The grant is then sampled (GAP+1) edges after the previous event.

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_gcnt_nxt  = r_gcnt;
        w_grant_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        case (r_state)
            IDLE, REPORT: begin
                w_gcnt_nxt = 4'd0;
                if (req) begin
                    w_gap_nxt = GAP_L;
                    if (GAP_L == 4'd0) begin
                        w_state_nxt = GRANT;
                        w_grant_nxt = 1'b1;
                    end else begin
                        w_state_nxt = GAP_WAIT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GAP_WAIT: begin
                if (!req) begin
                    // Requester gave up before its last grant.
                    w_state_nxt = REPORT;
                    w_abort_nxt = 1'b1;
                    w_gcnt_nxt  = 4'd0;
                end else begin
                    w_gap_nxt = w_gap_dec;
                    if (w_gap_dec == 4'd0) begin
                        w_state_nxt = GRANT;
                        w_grant_nxt = 1'b1;
                    end
                end
            end
            GRANT: begin
                w_gcnt_nxt = w_gcnt_inc;
                if (w_gcnt_inc == GC_L) begin
                    // Last grant: req on this edge is don't-care.
                    w_state_nxt = CHECK;
                end else if (!req) begin
                    w_state_nxt = REPORT;
                    w_abort_nxt = 1'b1;
                    w_gcnt_nxt  = 4'd0;
                end else begin
                    w_gap_nxt = GAP_L;
                    if (GAP_L == 4'd0) begin
                        w_state_nxt = GRANT;
                        w_grant_nxt = 1'b1;
                    end else begin
                        w_state_nxt = GAP_WAIT;
                    end
                end
            end
            CHECK: begin
                w_state_nxt = REPORT;
                w_gcnt_nxt  = 4'd0;
                if (req) begin
                    w_perr_nxt = 1'b1;
                end else begin
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gcnt_nxt  = 4'd0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == GAP_WAIT) || (w_state_nxt == GRANT) ||
                     (w_state_nxt == CHECK);
    end

    // State, counters and output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gap   <= 4'd0;
            r_gcnt  <= 4'd0;
            r_grant <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_perr  <= w_perr_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    // Saturating error tally. It steps on the same edge that raises the
    // error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if ((w_perr_nxt || w_abort_nxt) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign done      = r_done;
    assign proto_err = r_perr;
    assign abort     = r_abort;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_burst_grant_responder.sv
// Directed bench for burst_grant_responder.
// Two instances share the clock and reset: dut0 uses GAP=1 and dut1 uses GAP=0,
// and both use GRANT_COUNT=3.
// Observed vectors are packed as {grant, busy, done, proto_err, abort}.
// Each vector is captured before edge En, so it holds the values sampled at En.
module tb_burst_grant_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       grant0, busy0, done0, perr0, abort0;
    logic       grant1, busy1, done1, perr1, abort1;
    logic [7:0] err0, err1;

    logic [4:0] obs0, obs1;
    logic [7:0] ec0, ec1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    burst_grant_responder #(.GRANT_COUNT(3), .GAP(1)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .grant(grant0), .busy(busy0),
        .done(done0), .proto_err(perr0), .abort(abort0), .err_cnt(err0)
    );

    burst_grant_responder #(.GRANT_COUNT(3), .GAP(0)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .grant(grant1), .busy(busy1),
        .done(done1), .proto_err(perr1), .abort(abort1), .err_cnt(err1)
    );

    // Capture the outputs, drive the inputs that are sampled at the next edge,
    // and then take that edge.
    task automatic step(input logic r0, input logic r1, input logic rs);
        @(negedge clk);
        obs0 = {grant0, busy0, done0, perr0, abort0};
        obs1 = {grant1, busy1, done1, perr1, abort1};
        ec0  = err0;
        ec1  = err1;
        req0 = r0;
        req1 = r1;
        rst  = rs;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0 !== 5'b00000 || ec0 !== 8'd0) begin
            errors++;
            $display("FAIL reset dut0: got %b/%0d expected 00000/0", obs0, ec0);
        end
        checks++;
        if (obs1 !== 5'b00000 || ec1 !== 8'd0) begin
            errors++;
            $display("FAIL reset dut1: got %b/%0d expected 00000/0", obs1, ec1);
        end
        // Idle with req low stays quiet.
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (obs0 !== 5'b00000 || obs1 !== 5'b00000) begin
                errors++;
                $display("FAIL idle_quiet %0d: got %b %b expected 00000", n, obs0, obs1);
            end
        end
    endtask

    // GAP=1: req is held through E6 and dropped at E7, so done appears at E8.
    task automatic test_nominal();
        logic [4:0] ev [0:9];
        ev = '{5'b00000, 5'b01000, 5'b11000, 5'b01000, 5'b11000,
               5'b01000, 5'b11000, 5'b01000, 5'b00100, 5'b00000};
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step(n <= 6, 1'b0, 1'b0);
            checks++;
            if (obs0 !== ev[n]) begin
                errors++;
                $display("FAIL nominal E%0d: got %b expected %b", n, obs0, ev[n]);
            end
        end
        checks++;
        if (ec0 !== 8'd0) begin
            errors++;
            $display("FAIL nominal_errcnt: got %0d expected 0", ec0);
        end
    endtask

    // req is held through the check edge: proto_err appears at E8.
    // A new burst starts there, and the req drop at E15 ends it with done.
    task automatic test_proto_err();
        logic [4:0] ev [0:16];
        ev = '{5'b00000, 5'b01000, 5'b11000, 5'b01000, 5'b11000, 5'b01000,
               5'b11000, 5'b01000, 5'b00010, 5'b01000, 5'b11000, 5'b01000,
               5'b11000, 5'b01000, 5'b11000, 5'b01000, 5'b00100};
        do_reset();
        for (int n = 0; n < 17; n++) begin
            step(n <= 14, 1'b0, 1'b0);
            checks++;
            if (obs0 !== ev[n]) begin
                errors++;
                $display("FAIL proto_err E%0d: got %b expected %b", n, obs0, ev[n]);
            end
        end
        checks++;
        if (ec0 !== 8'd1) begin
            errors++;
            $display("FAIL proto_err_errcnt: got %0d expected 1", ec0);
        end
    endtask

    // req is low at Elast (E6) and high again at Ec.
    // The low at Elast is ignored, so the outcome is proto_err and not abort.
    task automatic test_elast_ignored();
        logic [4:0] ev [0:9];
        ev = '{5'b00000, 5'b01000, 5'b11000, 5'b01000, 5'b11000,
               5'b01000, 5'b11000, 5'b01000, 5'b00010, 5'b00000};
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step((n <= 5) || (n == 7), 1'b0, 1'b0);
            checks++;
            if (obs0 !== ev[n]) begin
                errors++;
                $display("FAIL elast_ignored E%0d: got %b expected %b", n, obs0, ev[n]);
            end
        end
    endtask

    // req is dropped at E3, before the last grant.
    // abort appears at E4, and no further grant is issued.
    task automatic test_abort();
        logic [4:0] ev [0:6];
        ev = '{5'b00000, 5'b01000, 5'b11000, 5'b01000, 5'b00001, 5'b00000, 5'b00000};
        do_reset();
        for (int n = 0; n < 7; n++) begin
            step(n <= 2, 1'b0, 1'b0);
            checks++;
            if (obs0 !== ev[n]) begin
                errors++;
                $display("FAIL abort E%0d: got %b expected %b", n, obs0, ev[n]);
            end
        end
        checks++;
        if (ec0 !== 8'd1) begin
            errors++;
            $display("FAIL abort_errcnt: got %0d expected 1", ec0);
        end
    endtask

    // GAP=0: grants land on E1, E2 and E3, and done appears at E5.
    task automatic test_back_to_back();
        logic [4:0] ev [0:6];
        ev = '{5'b00000, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 5'b00100, 5'b00000};
        do_reset();
        for (int n = 0; n < 7; n++) begin
            step(1'b0, n <= 3, 1'b0);
            checks++;
            if (obs1 !== ev[n]) begin
                errors++;
                $display("FAIL back_to_back E%0d: got %b expected %b", n, obs1, ev[n]);
            end
        end
    endtask

    // Reset is applied at E3 of a GAP=1 burst.
    // A fresh burst starts at E5, with grants at E7, E9 and E11.
    // err_cnt starts at 1, left over from the abort test, and reset clears it.
    task automatic test_reset_mid();
        logic [4:0] ev [0:13];
        ev = '{5'b00000, 5'b01000, 5'b11000, 5'b01000, 5'b00000, 5'b00000, 5'b01000,
               5'b11000, 5'b01000, 5'b11000, 5'b01000, 5'b11000, 5'b01000, 5'b00100};
        for (int n = 0; n < 14; n++) begin
            step((n <= 3) || (n >= 5 && n <= 11), 1'b0, n == 3);
            checks++;
            if (obs0 !== ev[n]) begin
                errors++;
                $display("FAIL reset_mid E%0d: got %b expected %b", n, obs0, ev[n]);
            end
            if (n == 4) begin
                checks++;
                if (ec0 !== 8'd0) begin
                    errors++;
                    $display("FAIL reset_mid_errcnt: got %0d expected 0", ec0);
                end
            end
        end
    endtask

    // GAP=0 with req held forever gives one proto_err at every edge 5k,
    // where the pulse count is k. err_cnt must stop at 255.
    task automatic test_saturate();
        do_reset();
        for (int n = 0; n <= 1300; n++) begin
            step(1'b0, 1'b1, 1'b0);
            if (n == 1270 || n == 1275 || n == 1280 || n == 1300) begin
                checks++;
                if (ec1 !== ((n == 1270) ? 8'd254 : 8'd255) || obs1 !== 5'b00010) begin
                    errors++;
                    $display("FAIL saturate E%0d: got %0d/%b expected %0d/00010",
                             n, ec1, obs1, (n == 1270) ? 254 : 255);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_proto_err();
        test_elast_ignored();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
